// File: rtl/dds_pkg.sv
// Shared definitions for the DDS waveform capture stage.
//   state_t   : capture FSM states
//   DW_DEF    : default sample width (matches DDS data_out)
//   EDGE_RISE / EDGE_FALL : values of the trig_edge input
package dds_pkg;

  localparam int DW_DEF = 8;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREFILL,
    ST_ARMED,
    ST_POST,
    ST_READOUT
  } state_t;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port capture buffer: one write port, one registered read port.
// Written in the plain inferable form so it maps onto block RAM.
//   i_clk               : clock
//   i_we/i_waddr/i_wdata: write port
//   i_re/i_raddr        : read request; o_rdata valid the cycle after i_re
module capture_ram #(
  parameter int DW = 8,
  parameter int AW = 10
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dds_wave_capture.sv
// Triggered waveform capture behind the DDS generator.
// Decimates din into a circular buffer, waits for a level crossing (or a
// forced trigger), keeps PRE samples before and DEPTH-PRE-1 after the trigger
// sample, then streams the DEPTH-sample window out over valid/ready.
//   sys_clk, sys_rst        : clock, synchronous active-high reset
//   din                     : DDS sample, valid every cycle
//   decim_ctl               : store one sample every decim_ctl+1 cycles
//   trig_level, trig_edge   : threshold and edge select (EDGE_RISE/EDGE_FALL)
//   arm, force_trig         : start a capture / trigger immediately when armed
//   out_data/valid/ready/last : window readout stream
//   busy, triggered         : status
module dds_wave_capture
  import dds_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int AW  = 10,
  parameter int PRE = 256
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic [DW-1:0] din,
  input  logic [15:0]   decim_ctl,
  input  logic [DW-1:0] trig_level,
  input  logic          trig_edge,
  input  logic          arm,
  input  logic          force_trig,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          triggered
);

  localparam int            DEPTH     = 1 << AW;
  localparam int            POST_N    = DEPTH - PRE - 1;
  localparam logic [AW-1:0] PRE_A     = AW'(PRE);
  localparam logic [AW-1:0] PRE_LAST  = AW'(PRE - 1);
  localparam logic [AW-1:0] POST_LAST = AW'(POST_N - 1);

  state_t        r_state, w_state_nx;
  logic [15:0]   r_dec, r_dec_lim, w_lim;
  logic [AW-1:0] r_wr_ptr, r_cnt, r_trig_ptr, r_rd_ptr;
  logic [DW-1:0] r_prev;
  logic          r_trig;

  logic [AW:0]   r_issued;
  logic          r_pend, r_pend_last;
  logic [DW-1:0] r_out_data, r_sk_data;
  logic          r_out_valid, r_out_last, r_sk_valid, r_sk_last;

  logic          w_capt, w_strobe, w_lvl_hit, w_fire, w_pop, w_issue, w_done;
  logic [AW-1:0] w_fire_ptr, w_tp;
  logic [1:0]    w_occ;
  logic [DW-1:0] w_rdata;

  capture_ram #(.DW(DW), .AW(AW)) u_ram (
    .i_clk  (sys_clk),
    .i_we   (w_strobe),
    .i_waddr(r_wr_ptr),
    .i_wdata(din),
    .i_re   (w_issue),
    .i_raddr(r_rd_ptr),
    .o_rdata(w_rdata)
  );

  always_comb begin
    w_capt   = (r_state == ST_PREFILL) || (r_state == ST_ARMED) || (r_state == ST_POST);
    // The limit is latched at each wrap so a decim_ctl change lands on the next period.
    w_lim    = (r_dec == '0) ? decim_ctl : r_dec_lim;
    w_strobe = w_capt && (r_dec == '0);
    if (trig_edge == EDGE_RISE)
      w_lvl_hit = (r_prev < trig_level) && (din >= trig_level);
    else
      w_lvl_hit = (r_prev > trig_level) && (din <= trig_level);
    w_fire     = (r_state == ST_ARMED) && ((w_strobe && w_lvl_hit) || force_trig);
    // On a strobe the sample being written is the trigger sample; otherwise
    // a forced trigger points at the most recently written address.
    w_fire_ptr = w_strobe ? r_wr_ptr : (r_wr_ptr - AW'(1));
    w_tp       = (r_state == ST_ARMED) ? w_fire_ptr : r_trig_ptr;

    w_pop  = r_out_valid && out_ready;
    // Entries held or in flight after this cycle must fit in out + skid.
    w_occ  = 2'(r_out_valid) + 2'(r_sk_valid) + 2'(r_pend) - 2'(w_pop);
    w_issue = (r_state == ST_READOUT) && (r_issued != (AW+1)'(DEPTH)) && (w_occ <= 2'd1);
    w_done  = w_pop && r_out_last;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      ST_IDLE:    if (arm) w_state_nx = ST_PREFILL;
      ST_PREFILL: if (w_strobe && (r_cnt == PRE_LAST)) w_state_nx = ST_ARMED;
      ST_ARMED:   if (w_fire) w_state_nx = (POST_N == 0) ? ST_READOUT : ST_POST;
      ST_POST:    if (w_strobe && (r_cnt == POST_LAST)) w_state_nx = ST_READOUT;
      ST_READOUT: if (w_done) w_state_nx = ST_IDLE;
      default:    w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= ST_IDLE;
    else         r_state <= w_state_nx;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_dec       <= '0;
      r_dec_lim   <= '0;
      r_wr_ptr    <= '0;
      r_cnt       <= '0;
      r_trig_ptr  <= '0;
      r_rd_ptr    <= '0;
      r_prev      <= '0;
      r_trig      <= 1'b0;
      r_issued    <= '0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_sk_data   <= '0;
      r_sk_valid  <= 1'b0;
      r_sk_last   <= 1'b0;
    end else begin
      if (!w_capt) begin
        r_dec <= '0;
      end else begin
        r_dec <= (r_dec == w_lim) ? '0 : r_dec + 16'd1;
        if (r_dec == '0) r_dec_lim <= decim_ctl;
      end

      if (w_strobe) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_prev   <= din;
      end

      if (r_state != w_state_nx)
        r_cnt <= '0;
      else if (w_strobe)
        r_cnt <= r_cnt + AW'(1);

      if (w_fire) begin
        r_trig_ptr <= w_fire_ptr;
        r_trig     <= 1'b1;
      end else if (w_done) begin
        r_trig <= 1'b0;
      end

      if ((w_state_nx == ST_READOUT) && (r_state != ST_READOUT))
        r_rd_ptr <= w_tp - PRE_A;
      else if (w_issue)
        r_rd_ptr <= r_rd_ptr + AW'(1);

      if (r_state != ST_READOUT) r_issued <= '0;
      else if (w_issue)          r_issued <= r_issued + (AW+1)'(1);

      r_pend      <= w_issue;
      r_pend_last <= w_issue && (r_issued == (AW+1)'(DEPTH - 1));

      // Output register refills from the skid first, then from the RAM;
      // RAM data arriving while the output is stalled parks in the skid.
      if (!r_out_valid || w_pop) begin
        if (r_sk_valid) begin
          r_out_data  <= r_sk_data;
          r_out_valid <= 1'b1;
          r_out_last  <= r_sk_last;
          r_sk_valid  <= r_pend;
          r_sk_data   <= w_rdata;
          r_sk_last   <= r_pend_last;
        end else if (r_pend) begin
          r_out_data  <= w_rdata;
          r_out_valid <= 1'b1;
          r_out_last  <= r_pend_last;
        end else begin
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end
      end else if (r_pend) begin
        r_sk_data  <= w_rdata;
        r_sk_valid <= 1'b1;
        r_sk_last  <= r_pend_last;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign busy      = (r_state != ST_IDLE);
  assign triggered = r_trig;

endmodule

// File: tb/tb_dds_wave_capture.sv
module tb_dds_wave_capture;

  localparam int PRE    = 256;
  localparam int DEPTH  = 1024;
  localparam int BUDGET = 20000;

  // wave: 0 ramp, 1 sine, 2 const 50, 3 random
  typedef struct {
    int wave;
    int decim;
    int lvl;
    int edg;
    int bp;
    int frc_at;
    int exp_trig;
  } vec_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [7:0]  din = '0;
  logic [15:0] decim_ctl = '0;
  logic [7:0]  trig_level = '0;
  logic        trig_edge = 1'b0;
  logic        arm = 1'b0;
  logic        force_trig = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic        busy;
  logic        triggered;

  dds_wave_capture dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .din       (din),
    .decim_ctl (decim_ctl),
    .trig_level(trig_level),
    .trig_edge (trig_edge),
    .arm       (arm),
    .force_trig(force_trig),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .triggered (triggered)
  );

  always #10 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cur_wave = 0;
  int cur_bp = 0;
  int cur_frc = -1;
  bit rec = 0;
  bit done = 0;
  bit hold_chk = 0;
  int hold_data = 0;
  int trig_at_last = 0;
  int hist[$];
  int s[$];
  int got[$];
  int lastv[$];
  int ref_win[$];
  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int wave_val(input int w, input int c);
    case (w)
      0: return c % 256;
      1: return $rtoi(128.0 + 100.0 * $sin(6.283185307179586 * real'(c % 50) / 50.0));
      2: return 50;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  // One clock: observe outputs just after the edge, then drive the next cycle.
  task automatic step();
    logic rdy;
    int idx;
    @(posedge sys_clk);
    #1;
    cyc++;
    if (hold_chk) begin
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_data", int'(out_data), hold_data);
    end
    rdy = (cur_bp != 0) ? ($urandom_range(0, 1) == 1) : 1'b1;
    out_ready = rdy;
    if (out_valid && rdy) begin
      got.push_back(int'(out_data));
      lastv.push_back(int'(out_last));
      if (out_last) begin
        done = 1;
        trig_at_last = int'(triggered);
      end
    end
    hold_chk  = out_valid && !rdy;
    hold_data = int'(out_data);
    din = 8'(wave_val(cur_wave, cyc));
    arm = 1'b0;
    force_trig = 1'b0;
    if (rec) begin
      hist.push_back(int'(din));
      idx = hist.size() - 1;
      if (idx == 10) arm = 1'b1;  // arm while busy must be ignored
      if (cur_frc >= 0 && (idx == 100 || idx == cur_frc)) force_trig = 1'b1;
    end
  endtask

  function automatic int find_trig(input int lvl, input int edg, input int fj);
    for (int j = PRE; j < s.size(); j++) begin
      if (fj >= 0 && fj <= j) return fj;
      if (edg == 0 ? (s[j-1] < lvl && s[j] >= lvl) : (s[j-1] > lvl && s[j] <= lvl)) return j;
    end
    return -1;
  endfunction

  task automatic run_vec(input vec_t v, input int abort_at, input int save_ref, input int cmp_ref);
    int d, t, nbad, fbad, nlast, lpos, nnot50;
    decim_ctl  = 16'(v.decim);
    trig_level = 8'(v.lvl);
    trig_edge  = v.edg[0];
    cur_wave = v.wave;
    cur_bp   = v.bp;
    cur_frc  = v.frc_at;
    hist.delete(); got.delete(); lastv.delete();
    done = 0; rec = 0; hold_chk = 0;
    step();
    if (v.frc_at >= 0) force_trig = 1'b1;
    step();
    step();
    chk("idle_busy", int'(busy), 0);
    chk("idle_triggered", int'(triggered), 0);
    arm = 1'b1;
    rec = 1;
    for (int c = 0; c < BUDGET && !done; c++) begin
      step();
      if (v.frc_at >= 0 && hist.size() == 300) begin
        chk("armed_busy", int'(busy), 1);
        chk("no_early_trigger", int'(triggered), 0);
      end
      if (abort_at >= 0 && got.size() == abort_at) begin
        sys_rst = 1'b1;
        hold_chk = 0;
        step();
        sys_rst = 1'b0;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_triggered", int'(triggered), 0);
        rec = 0;
        return;
      end
    end
    rec = 0;
    if (!done) begin
      chk("timeout_waiting_last", 0, 1);
      return;
    end
    chk("triggered_during_readout", trig_at_last, 1);
    step();
    chk("end_busy", int'(busy), 0);
    chk("end_triggered", int'(triggered), 0);
    chk("sample_count", got.size(), DEPTH);
    if (got.size() != DEPTH) return;

    nlast = 0; lpos = -1; nnot50 = 0;
    foreach (lastv[i]) if (lastv[i] != 0) begin nlast++; lpos = i; end
    chk("last_count", nlast, 1);
    chk("last_pos", lpos, DEPTH - 1);

    d = v.decim + 1;
    s.delete();
    for (int k = 0; k < hist.size(); k += d) s.push_back(hist[k]);
    t = find_trig(v.lvl, v.edg, (v.frc_at >= 0) ? v.frc_at / d : -1);
    if (t < 0 || t - PRE + DEPTH > s.size()) begin
      chk("model_window_available", 0, 1);
    end else begin
      nbad = 0; fbad = -1;
      for (int i = 0; i < DEPTH; i++)
        if (got[i] != s[t - PRE + i]) begin
          nbad++;
          if (fbad < 0) fbad = i;
        end
      chk($sformatf("window_mismatches(first idx %0d)", fbad), nbad, 0);
    end
    if (v.exp_trig >= 0) chk("trigger_sample", got[PRE], v.exp_trig);
    if (v.frc_at < 0) begin
      if (v.edg == 0) begin
        chk("rise_before", int'(got[PRE-1] < v.lvl), 1);
        chk("rise_at", int'(got[PRE] >= v.lvl), 1);
      end else begin
        chk("fall_before", int'(got[PRE-1] > v.lvl), 1);
        chk("fall_at", int'(got[PRE] <= v.lvl), 1);
      end
    end
    if (v.wave == 0) chk("ramp_step", (got[PRE] - got[PRE-1]) & 255, d % 256);
    if (v.wave == 2) begin
      foreach (got[i]) if (got[i] != 50) nnot50++;
      chk("const_not_50", nnot50, 0);
    end
    if (save_ref != 0) ref_win = got;
    if (cmp_ref != 0) begin
      nbad = 0;
      for (int i = 0; i < DEPTH; i++) if (got[i] != ref_win[i]) nbad++;
      chk("backpressure_same_as_free_run", nbad, 0);
    end
  endtask

  initial begin
    vecs[0] = '{0, 0, 100, 0, 0, -1, 100};
    vecs[1] = '{0, 3, 100, 0, 0, -1, -1};
    vecs[2] = '{1, 0, 128, 1, 0, -1, -1};
    vecs[3] = '{2, 0, 200, 0, 0, 400, 50};
    vecs[4] = '{0, 0, 100, 0, 1, -1, 100};
    vecs[5] = '{3, int'($urandom_range(0, 2)), int'($urandom_range(20, 235)),
                int'($urandom_range(0, 1)), 1, -1, -1};
    vecs[6] = '{1, 1, 60, 0, 1, -1, -1};

    sys_rst = 1'b1;
    step(); step(); step();
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_last", int'(out_last), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_triggered", int'(triggered), 0);
    chk("reset_data", int'(out_data), 0);
    sys_rst = 1'b0;
    step();

    for (int n = 0; n < 7; n++)
      run_vec(vecs[n], -1, (n == 0) ? 1 : 0, (n == 4) ? 1 : 0);

    run_vec(vecs[0], 500, 0, 0);
    step();
    run_vec(vecs[0], -1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
